// File: rtl/alu_datapath.sv
// Register/adder datapath for the 8-bit ALU: A, Q, M, Q-1, counter, result latch; optional ALU_DP_OVF_EN adds a signed-overflow flag.
// Latency: every strobe lands on the edge that samples it, status decodes follow combinationally, out_valid pulses the cycle after c7.
// Backpressure: none; the control unit owns sequencing and the datapath accepts a strobe every cycle.
module alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     inbus,
    input  logic                 c0,
    input  logic                 c1,
    input  logic                 c2,
    input  logic                 c3,
    input  logic                 c4,
    input  logic                 c5,
    input  logic                 c6,
    input  logic                 c7,
    output logic                 q0,
    output logic                 qm1,
    output logic                 a7,
    output logic                 cnt_done,
    output logic [2*WIDTH-1:0]   outbus,
    output logic                 out_valid,
    output logic                 ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q, q_q, m_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] outbus_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   left_opnd, m_eff, sum, a_src;
    logic [WIDTH-1:0]   a_nxt, q_nxt;
    logic               qm1_nxt;
    logic [2*WIDTH-1:0] result;

    // Subtraction is add of ~M with carry-in, so the overflow check can use m_eff's sign directly.
    assign left_opnd = op[1] ? a_q : q_q;
    assign m_eff     = c3 ? ~m_q : m_q;
    assign sum       = left_opnd + m_eff + {{(WIDTH-1){1'b0}}, c3};
    assign a_src     = c2 ? sum : a_q;
    assign result    = op[1] ? {a_q, q_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};

    // Shift sees the adder output when c2 is also set; a c1 load wins over the shifted Q.
    always_comb begin
        a_nxt   = a_src;
        q_nxt   = q_q;
        qm1_nxt = qm1_q;
        if (c4 && op == 2'b10) begin
            a_nxt   = {a_src[WIDTH-1], a_src[WIDTH-1:1]};
            q_nxt   = {a_src[0], q_q[WIDTH-1:1]};
            qm1_nxt = q_q[0];
        end else if (c4 && op == 2'b11) begin
            a_nxt = {a_src[WIDTH-2:0], q_q[WIDTH-1]};
            q_nxt = {q_q[WIDTH-2:0], c6};
        end
        if (c1) begin
            q_nxt = inbus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            outbus_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= c7;
            if (c7) begin
                outbus_q <= result;
            end
            if (c0) begin
                m_q   <= inbus;
                a_q   <= '0;
                q_q   <= '0;
                qm1_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                a_q   <= a_nxt;
                q_q   <= q_nxt;
                qm1_q <= qm1_nxt;
                if (c5) begin
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef ALU_DP_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (c0) begin
            ovf_q <= 1'b0;
        end else if (c2 && !op[1]) begin
            ovf_q <= (left_opnd[WIDTH-1] == m_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != left_opnd[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign q0        = q_q[0];
    assign qm1       = qm1_q;
    assign a7        = a_q[WIDTH-1];
    assign cnt_done  = (cnt_q == CNT_LAST);
    assign outbus    = outbus_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed and randomized bench for alu_datapath; expected values come from signed integer arithmetic.
module tb_alu_datapath;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op;
    logic [W-1:0]  inbus;
    logic          c0, c1, c2, c3, c4, c5, c6, c7;
    logic          q0, qm1, a7, cnt_done;
    logic [2*W-1:0] outbus;
    logic          out_valid;
    logic          ovf;

    int total = 0;
    int fails = 0;

    alu_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op(op), .inbus(inbus),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .q0(q0), .qm1(qm1), .a7(a7), .cnt_done(cnt_done),
        .outbus(outbus), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        {c0, c1, c2, c3, c4, c5, c6, c7} = '0;
    endtask

    task automatic load(input logic [1:0] o, input logic [W-1:0] mval, input logic [W-1:0] qval);
        op = o;
        c0 = 1'b1; inbus = mval; tick();
        c1 = 1'b1; inbus = qval; tick();
    endtask

    task automatic latch_check(input string tag, input logic [2*W-1:0] exp);
        c7 = 1'b1; tick();
        check({tag, "_out"}, 32'(outbus), 32'(exp));
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        tick();
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic exp_ovf(input logic model_ovf);
`ifdef ALU_DP_OVF_EN
        return model_ovf;
`else
        return 1'b0 & model_ovf;
`endif
    endfunction

    // Booth: control decisions come from the DUT's status bits, the expected product from integer multiply.
    task automatic booth(input string tag, input logic [W-1:0] mv, input logic [W-1:0] qv);
        int p;
        load(2'b10, mv, qv);
        for (int it = 0; it < W; it++) begin
            case ({q0, qm1})
                2'b10:   begin c2 = 1'b1; c3 = 1'b1; end
                2'b01:   begin c2 = 1'b1; c3 = 1'b0; end
                default: begin c2 = 1'b0; c3 = 1'b0; end
            endcase
            c4 = 1'b1; c5 = 1'b1;
            tick();
            check({tag, "_cnt_done"}, 32'(cnt_done), 32'(it == W - 2));
        end
        p = int'($signed(mv)) * int'($signed(qv));
        latch_check(tag, p[2*W-1:0]);
    endtask

    logic [W-1:0] x, y;
    logic         sub;
    int           r, hits;
    logic [W-1:0] r8;

    initial begin
        rst = 1'b1; op = 2'b00; inbus = '0;
        {c0, c1, c2, c3, c4, c5, c6, c7} = '0;
        tick();

        // Reset beats every strobe.
        rst = 1'b0; op = 2'b10; inbus = 8'hAB;
        {c0, c1, c2, c3, c4, c5, c6, c7} = '1;
        tick();
        rst = 1'b1;
        check("rst_outbus", 32'(outbus), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_status", 32'({q0, qm1, a7, cnt_done}), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Directed add 17+25 and sub 5-9.
        load(2'b00, 8'd17, 8'd25);
        c2 = 1'b1; c3 = 1'b0; tick();
        latch_check("add", 16'h002A);
        load(2'b01, 8'd9, 8'd5);
        c2 = 1'b1; c3 = 1'b1; tick();
        latch_check("sub", 16'hFFFC);

        // 0x7F + 0x01 overflows signed; c0 clears the flag.
        load(2'b00, 8'h01, 8'h7F);
        c2 = 1'b1; tick();
        check("ovf_set", 32'(ovf), 32'(exp_ovf(1'b1)));
        latch_check("ovf_add", 16'hFF80);
        c0 = 1'b1; inbus = 8'h00; tick();
        check("ovf_clr", 32'(ovf), 32'd0);

        // Random add/sub against signed integer arithmetic.
        for (int i = 0; i < 12; i++) begin
            x = W'($urandom); y = W'($urandom); sub = 1'($urandom_range(0, 1));
            load({1'b0, sub}, y, x);
            c2 = 1'b1; c3 = sub; tick();
            r = sub ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
            r8 = r[W-1:0];
            check("rnd_addsub_ovf", 32'(ovf), 32'(exp_ovf(r > 127 || r < -128)));
            latch_check("rnd_addsub", {{W{r8[W-1]}}, r8});
        end

        // Booth multiply: directed -3*7 then random signed pairs.
        booth("mul_m3x7", 8'hFD, 8'h07);
        for (int i = 0; i < 6; i++) begin
            booth("rnd_mul", W'($urandom), W'($urandom));
        end

        // Left shift of {A,Q} with c6 entering Q[0].
        load(2'b11, 8'h00, 8'h80);
        c4 = 1'b1; c6 = 1'b1; tick();
        check("lsh_q0", 32'(q0), 32'd1);
        check("lsh_a7", 32'(a7), 32'd0);
        check("lsh_qm1", 32'(qm1), 32'd0);
        c7 = 1'b1; tick();
        c7 = 1'b1; tick();
        check("b2b_vld", 32'(out_valid), 32'd1);
        check("lsh_out", 32'(outbus), 32'h0101);
        tick();
        check("b2b_drop", 32'(out_valid), 32'd0);

        // Single-edge add-and-arithmetic-shift: (0+6)>>>1=3, Q 0x03 -> 0x01, Q-1 takes old Q[0].
        load(2'b10, 8'h06, 8'h03);
        c2 = 1'b1; c4 = 1'b1; tick();
        check("addsh_qm1", 32'(qm1), 32'd1);
        check("addsh_q0", 32'(q0), 32'd1);
        latch_check("addsh", 16'h0301);
        // Negative: (0 + -10)>>>1 = -5.
        load(2'b10, 8'hF6, 8'h02);
        c2 = 1'b1; c4 = 1'b1; tick();
        check("addsh_neg_a7", 32'(a7), 32'd1);
        latch_check("addsh_neg", 16'hFB01);

        // Counter wraps after W increments with exactly one done cycle.
        op = 2'b00; c0 = 1'b1; tick();
        hits = 0;
        for (int i = 0; i < W; i++) begin
            c5 = 1'b1; tick();
            if (cnt_done) hits++;
        end
        check("cnt_done_hits", 32'(hits), 32'd1);
        check("cnt_wrapped", 32'(cnt_done), 32'd0);
        for (int i = 0; i < W - 1; i++) begin
            c5 = 1'b1; tick();
        end
        check("cnt_after_wrap", 32'(cnt_done), 32'd1);

        // Reset partway through counting restarts from zero.
        c0 = 1'b1; tick();
        for (int i = 0; i < W / 2; i++) begin
            c5 = 1'b1; tick();
        end
        rst = 1'b0; c5 = 1'b1; tick();
        rst = 1'b1;
        check("rst_mid_done", 32'(cnt_done), 32'd0);
        for (int i = 0; i < W - 1; i++) begin
            c5 = 1'b1; tick();
        end
        check("rst_mid_cnt", 32'(cnt_done), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Arithmetic datapath for the 8-bit ALU. It holds the A, Q, M and Q₋₁ registers, the add/subtract unit and the iteration counter. It executes the c0–c7 control strobes issued each cycle by the ALU control unit, and returns the status bits (q0, qm1, a7, cnt_done) that the control unit branches on. It latches the final 16-bit result for the system.

## Interface
- WIDTH, 8: operand width; A, Q and M are WIDTH bits wide, the result is 2·WIDTH bits wide.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- op  input  2  operation: 00 add, 01 sub, 10 mul (Booth), 11 div. Selects the shift direction and the adder's left operand.
- inbus  input  WIDTH  operand input.
- c0  input  1  load inbus into M; clear A, Q, Q₋₁ and cnt.
- c1  input  1  load inbus into Q.
- c2  input  1  load adder result into A.
- c3  input  1  adder function: 0 = add M, 1 = subtract M.
- c4  input  1  shift enable; shift once per cycle while high.
- c5  input  1  increment the counter once per cycle while high.
- c6  input  1  bit shifted into Q[0] on a left shift.
- c7  input  1  latch the result into outbus.
- q0  output  1  Q[0].
- qm1  output  1  Q₋₁.
- a7  output  1  A[WIDTH-1].
- cnt_done  output  1  high when cnt == WIDTH-1.
- outbus  output  2·WIDTH  latched result.
- out_valid  output  1  one-cycle pulse in the cycle after a c7 strobe.
- ovf  output  1  signed overflow flag (see Configuration).

## Operation
- Registers: A, Q, M (WIDTH bits each); Q₋₁ (1 bit); cnt (log2(WIDTH) bits); outbus; out_valid.
- Adder:
  - Left operand is Q when op[1]=0, and A when op[1]=1.
  - Result is left + M when c3=0, and left + ~M + 1 when c3=1.
  - Result is truncated to WIDTH bits.
- Priority within a cycle: rst > c0 > (c1, c2, c4, c5, c7 applied together).
  - c0 clears A/Q/Q₋₁/cnt and loads M. Every other strobe in that cycle is ignored except c7.
  - c7 latches the pre-edge register contents.
- c1 with c4: the shift acts on the old Q, and then c1 overwrites Q.
- c2 with c4: the shift acts on the adder result, not on the old A. This gives a one-cycle Booth add-and-shift.
- Shift when op=10 (arithmetic right):
  - {A,Q,Q₋₁} ← {A[MSB], A, Q}.
  - c6 is ignored.
- Shift when op=11 (left):
  - {A,Q} ← {A[MSB-1:0], Q, c6}.
  - Q₋₁ is unchanged.
- Shift when op[1]=0: c4 is ignored and no shift occurs.
- Counter:
  - c5 increments cnt by 1.
  - The counter wraps from WIDTH-1 to 0 without saturating.
  - Only c0 and rst clear it.
- c7 latches outbus as follows:
  - op[1]=0: {{WIDTH{A[MSB]}}, A}, i.e. the sign-extended sum or difference.
  - op=10: {A,Q}, the product.
  - op=11: {A,Q}, with remainder in A and quotient in Q.
- Status outputs are combinational decodes of the registers and carry no extra latency.
- Reset values: A, Q, M, Q₋₁, cnt, outbus, out_valid and ovf are all 0. Therefore q0 = qm1 = a7 = cnt_done = 0.

## Timing
- Every strobe takes effect on the edge that samples it. Status outputs reflect the new values in the following cycle.
- The control unit may sample q0, qm1, a7 and cnt_done in the cycle directly after an update; no pipeline bubble is required.
- out_valid is high for exactly one cycle, the cycle after c7 is sampled, and outbus is stable from that cycle on.
- Back-to-back c7: outbus updates every cycle and out_valid stays high.
- Reset mid-operation: rst=0 at an edge clears all state regardless of the strobes. Operation resumes only after the control unit reissues c0.
- op must be held stable for the whole operation. A change of op mid-operation yields an undefined result but no lockup.

## Configuration
- ALU_DP_OVF_EN defined:
  - On each c2 with op[1]=0, ovf latches the signed overflow: both operands have the same effective sign and the result sign differs.
  - ovf is cleared by c0 or rst and held otherwise.
- ALU_DP_OVF_EN undefined: the ovf port is present and tied to 0, and no overflow logic is generated.

## Test plan
- Reset with all strobes active: rst=0 plus c0..c7=1 for one edge → all outputs 0, out_valid 0.
- Add: c0 with inbus=17, c1 with inbus=25, op=00, c2 with c3=0, then c7 → outbus=0x002A and out_valid pulses once. Sub 5−9 (c1=5, c0=9, c3=1) → outbus=0xFFFC.
- Booth multiply −3×7: op=10, M=0xFD, Q=0x07; the bench drives the c2/c3/c4/c5 sequence from qm1 and q0 for 8 iterations, then c7 → outbus=0xFFEB. cnt_done rises after the 7th c5.
- Left shift: op=11, A=0x00, Q=0x80, c4 with c6=1 → A=0x01, Q=0x01, q0=1, a7=0. Combined c2+c4 with op=10: A ← (A+M)>>>1 in a single edge.
- Counter wrap: 8 consecutive c5 pulses from 0 → cnt_done high in exactly one of those cycles (at cnt=7), then cnt=0. rst=0 halfway through → cnt=0 on the next edge.
- With ALU_DP_OVF_EN defined: add 0x7F+0x01 → ovf=1 and outbus=0xFF80. A following c0 → ovf=0.
